relu_maxpool2x2: RTL

Downstream stage of the 3x3 Conv2d datapath. It consumes the raster-order stream of signed 36-bit convolution results qualified by en. Each result is requantized by an arithmetic right shift, passed through ReLU and saturated to an unsigned 8-bit pixel. The block then applies a 2x2, stride-2 max pool using a half-width row buffer and emits one pooled pixel per 2x2 window.

---
 rtl/relu_maxpool2x2_pkg.sv | 9 +
 rtl/relu_maxpool2x2_if.sv | 12 +
 rtl/relu_maxpool2x2_requant_relu.sv | 14 +
 rtl/relu_maxpool2x2.sv | 76 +++++++
 4 files changed

// File: rtl/relu_maxpool2x2_pkg.sv
// relu_maxpool2x2_pkg: shared widths and helpers for the Conv2d ReLU/max-pool stage
package relu_maxpool2x2_pkg;
  localparam int CONV_OUT_W = 36;
  localparam int PIX_W = 8;
  localparam int PIX_MAX = 255;
  function automatic logic [PIX_W-1:0] pix_max(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/relu_maxpool2x2_if.sv
// relu_maxpool2x2_if: conv-result input stream and pooled-pixel output stream
interface relu_maxpool2x2_if;
  import relu_maxpool2x2_pkg::*;
  logic clr;
  logic in_valid;
  logic [CONV_OUT_W-1:0] in_data;
  logic out_valid;
  logic [PIX_W-1:0] out_data;
  logic frame_done;
  modport master(output clr, in_valid, in_data, input out_valid, out_data, frame_done);
  modport slave(input clr, in_valid, in_data, output out_valid, out_data, frame_done);
endinterface

// File: rtl/relu_maxpool2x2_requant_relu.sv
// requant_relu: arithmetic right shift, ReLU and unsigned 8-bit saturation
module requant_relu
  import relu_maxpool2x2_pkg::*;
#(
  parameter int SHIFT = 8
) (
  input  logic [CONV_OUT_W-1:0] in_data,
  output logic [PIX_W-1:0]      p
);
  logic signed [CONV_OUT_W-1:0] w_q;
  assign w_q = $signed(in_data) >>> SHIFT;
  assign p = w_q[CONV_OUT_W-1] ? '0 :
             (w_q > $signed(CONV_OUT_W'(PIX_MAX))) ? PIX_W'(PIX_MAX) : w_q[PIX_W-1:0];
endmodule

// File: rtl/relu_maxpool2x2.sv
// relu_maxpool2x2: requantize + ReLU the conv stream, then 2x2 stride-2 max pool
module relu_maxpool2x2
  import relu_maxpool2x2_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int SHIFT = 8
) (
  input logic clk,
  input logic rst,
  relu_maxpool2x2_if.slave s
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DEPTH = IMG_W / 2;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_END = CW'(2 * DEPTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_END = RW'(2 * (IMG_H / 2) - 1);
  localparam bit ROW_ODD = (IMG_H % 2) == 1;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [PIX_W-1:0] r_held;
  logic [PIX_W-1:0] r_buf [DEPTH];
  logic [PIX_W-1:0] r_out;
  logic r_valid;
  logic r_done;
  logic [PIX_W-1:0] w_p;
  logic [PIX_W-1:0] w_pair;
  logic [IW-1:0] w_idx;
  logic w_beat;
  logic w_row_drop;
  logic w_wr;
  logic w_emit;
  requant_relu #(.SHIFT(SHIFT)) u_requant (.in_data(s.in_data), .p(w_p));
  // odd columns are always inside a window; only a trailing odd row needs masking
  assign w_beat = s.in_valid & ~s.clr;
  assign w_row_drop = ROW_ODD && (r_row == ROW_LAST);
  assign w_pair = pix_max(r_held, w_p);
  assign w_idx = IW'(r_col >> 1);
  assign w_wr = w_beat & r_col[0] & ~r_row[0] & ~w_row_drop;
  assign w_emit = w_beat & r_col[0] & r_row[0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_held <= '0;
    end else if (s.clr) begin
      r_col <= '0;
      r_row <= '0;
      r_held <= '0;
    end else if (s.in_valid) begin
      if (!r_col[0]) r_held <= w_p;
      r_col <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
      if (r_col == COL_LAST) r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_done <= 1'b0;
      r_out <= '0;
    end else begin
      r_valid <= w_emit;
      r_done <= w_emit && (r_row == ROW_END) && (r_col == COL_END);
      if (w_emit) r_out <= pix_max(w_pair, r_buf[w_idx]);
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[w_idx] <= w_pair;
  end
  assign s.out_valid = r_valid;
  assign s.out_data = r_out;
  assign s.frame_done = r_done;
endmodule
